alu16_arbiter: RTL

Two-client arbiter and sequencer for the shared 16-bit ALU datapath (`ALU16bit`: add, subtract, multiply). It accepts operation requests from two requesters over valid/ready handshakes and grants them round-robin. It drives the single ALU instance with registered operands and returns a tagged result. The ALU's divide leg is not used: this block performs unsigned division itself as a 16-iteration restoring loop, using the ALU's subtract path for each iteration.

---
 rtl/alu16_arbiter_pkg.sv | 20 ++
 rtl/alu16_arbiter_alu.sv | 46 ++++
 rtl/alu16_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu16_arbiter_pkg.sv
// Shared opcode/state encodings and constants for the two-client ALU sequencer.
package alu16_arbiter_pkg;

  localparam int unsigned DIV_ITERS = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DIV  = 2'b10,
    S_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/alu16_arbiter_alu.sv
// Shared 16-bit ALU: add (ov = carry), sub (ov = borrow), mul (ov = high half nonzero).
module ALU16bit
  import alu16_arbiter_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   sel,
  output logic [W-1:0] alu_out,
  output logic         alu_ov
);

  logic [W:0]     sum_ext;
  logic [W:0]     diff_ext;
  logic [2*W-1:0] prod;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // The divide leg is left idle; the sequencer performs division itself.
  always_comb begin
    alu_out = '0;
    alu_ov  = 1'b0;
    case (op_e'(sel))
      OP_ADD: begin
        alu_out = sum_ext[W-1:0];
        alu_ov  = sum_ext[W];
      end
      OP_SUB: begin
        alu_out = diff_ext[W-1:0];
        alu_ov  = diff_ext[W];
      end
      OP_MUL: begin
        alu_out = prod[W-1:0];
        alu_ov  = |prod[2*W-1:W];
      end
      default: begin
        alu_out = '0;
        alu_ov  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu16_arbiter.sv
// Round-robin two-requester sequencer around one shared ALU16bit,
// with a 16-iteration restoring divider built on the ALU subtract path.
module alu16_arbiter
  import alu16_arbiter_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_op0,
  input  logic [1:0]   req_op1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_b1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_ov
);

  state_e       state, state_nxt;
  logic         rr;
  logic         lat_id;
  op_e          lat_op;
  logic [W-1:0] lat_a, lat_b;
  logic [W-1:0] rem, quo;
  logic [3:0]   cnt;

  logic         grant, gid;
  op_e          g_op;
  logic [W-1:0] g_a, g_b;

  logic [W-1:0] trial, alu_a, alu_out;
  logic [1:0]   alu_sel;
  logic         alu_ov, fits, last_iter;
  logic [W-1:0] rem_nxt, quo_nxt;

  // Requester at rr wins a tie; the other may take an uncontested slot.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE) begin
      req_ready[0] = req_valid[0] && (!rr || !req_valid[1]);
      req_ready[1] = req_valid[1] && ( rr || !req_valid[0]);
    end
  end

  assign grant = |req_ready;
  assign gid   = req_ready[1];
  assign g_op  = gid ? op_e'(req_op1) : op_e'(req_op0);
  assign g_a   = gid ? req_a1 : req_a0;
  assign g_b   = gid ? req_b1 : req_b0;

  assign last_iter = (cnt == 4'(DIV_ITERS - 1));
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = (g_op == OP_DIV && g_b != '0) ? S_DIV : S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_DIV:   if (last_iter) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Divider step: shift the next dividend bit into the partial remainder
  // and subtract the divisor on the ALU when it fits.
  assign trial   = {rem[W-2:0], quo[W-1]};
  assign fits    = (trial >= lat_b);
  assign rem_nxt = fits ? alu_out : trial;
  assign quo_nxt = {quo[W-2:0], fits};

  assign alu_a   = (state == S_DIV) ? trial : lat_a;
  assign alu_sel = (state == S_DIV) ? OP_SUB : lat_op;

  ALU16bit #(.W(W)) u_alu (
    .a       (alu_a),
    .b       (lat_b),
    .sel     (alu_sel),
    .alu_out (alu_out),
    .alu_ov  (alu_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= 1'b0;
      lat_id   <= 1'b0;
      lat_op   <= OP_ADD;
      lat_a    <= '0;
      lat_b    <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_ov   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            lat_id <= gid;
            lat_op <= g_op;
            lat_a  <= g_a;
            lat_b  <= g_b;
            rr     <= ~gid;
            if (g_op == OP_DIV && g_b != '0) begin
              rem <= '0;
              quo <= g_a;
              cnt <= '0;
            end
          end
        end
        S_EXEC: begin
          rsp_id <= lat_id;
          if (lat_op == OP_DIV) begin
            rsp_data <= '1;
            rsp_ov   <= 1'b1;
          end else begin
            rsp_data <= alu_out;
            rsp_ov   <= alu_ov;
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 4'd1;
          if (last_iter) begin
            rsp_data <= quo_nxt;
            rsp_ov   <= 1'b0;
            rsp_id   <= lat_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
